// File: rtl/gain_stage_mc.sv
// Multi-channel pipelined gain stage: per-channel gain table, multiply, scale, saturate.
// Optional round-half-up scaling is enabled by defining GAIN_STAGE_MC_ROUND_EN.
module gain_stage_mc #(
    parameter int GAIN_WIDTH      = 16,
    parameter int SHIFT_LEFT_SIZE = 12,
    parameter int DIN_WIDTH       = 16,
    parameter int DOUT_WIDTH      = 16,
    parameter int CH_WIDTH        = 2,
    parameter logic [GAIN_WIDTH-1:0] GAIN_RESET = 16'h1000,
    localparam int NUM_CH         = 1 << CH_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gain_we,
    input  logic [CH_WIDTH-1:0]   gain_addr,
    input  logic [GAIN_WIDTH-1:0] gain_wdata,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic [CH_WIDTH-1:0]   din_ch,
    input  logic                  din_v,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic [CH_WIDTH-1:0]   dout_ch,
    output logic                  dout_v,
    output logic                  dout_sat,
    output logic [NUM_CH-1:0]     sat_flags,
    input  logic                  sat_clr
);

    localparam int PW = DIN_WIDTH + GAIN_WIDTH;
    localparam logic [PW:0] DOUT_MAX = {{(PW + 1 - DOUT_WIDTH){1'b0}}, {DOUT_WIDTH{1'b1}}};
`ifdef GAIN_STAGE_MC_ROUND_EN
    localparam logic [PW:0] RND_ADD = {{PW{1'b0}}, 1'b1} << (SHIFT_LEFT_SIZE - 1);
`endif

    logic [GAIN_WIDTH-1:0] gain_q [NUM_CH];
    logic [GAIN_WIDTH-1:0] gain_d [NUM_CH];

    logic                  s1_v_q, s1_v_d;
    logic [DIN_WIDTH-1:0]  s1_din_q, s1_din_d;
    logic [CH_WIDTH-1:0]   s1_ch_q, s1_ch_d;
    logic [GAIN_WIDTH-1:0] s1_gain_q, s1_gain_d;

    logic                  s2_v_q, s2_v_d;
    logic [PW-1:0]         s2_prod_q, s2_prod_d;
    logic [CH_WIDTH-1:0]   s2_ch_q, s2_ch_d;

    logic [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic [CH_WIDTH-1:0]   dout_ch_q, dout_ch_d;
    logic                  dout_v_q, dout_v_d;
    logic                  dout_sat_q, dout_sat_d;
    logic [NUM_CH-1:0]     sat_flags_q, sat_flags_d;

    logic [PW:0]           sum_s;
    logic [PW:0]           q_s;
    logic                  sat_s;

    // Gain table write; the S1 read below sees the pre-write value at the same edge.
    always_comb begin
        gain_d = gain_q;
        if (gain_we) begin
            gain_d[gain_addr] = gain_wdata;
        end else begin
            gain_d = gain_q;
        end
    end

    // S1 capture and S2 full-width product.
    always_comb begin
        s1_v_d    = din_v;
        s1_din_d  = din;
        s1_ch_d   = din_ch;
        s1_gain_d = gain_q[din_ch];
        s2_v_d    = s1_v_q;
        s2_ch_d   = s1_ch_q;
        s2_prod_d = {{GAIN_WIDTH{1'b0}}, s1_din_q} * {{DIN_WIDTH{1'b0}}, s1_gain_q};
    end

    // S3 scaling and saturation; the extra top bit keeps the rounding add from wrapping.
    always_comb begin
`ifdef GAIN_STAGE_MC_ROUND_EN
        sum_s = {1'b0, s2_prod_q} + RND_ADD;
`else
        sum_s = {1'b0, s2_prod_q};
`endif
        q_s = sum_s >> SHIFT_LEFT_SIZE;
        if (q_s > DOUT_MAX) begin
            sat_s = 1'b1;
        end else begin
            sat_s = 1'b0;
        end
    end

    // Output registers hold their values between valid samples.
    always_comb begin
        dout_v_d = s2_v_q;
        if (s2_v_q) begin
            dout_ch_d  = s2_ch_q;
            dout_sat_d = sat_s;
            if (sat_s) begin
                dout_d = {DOUT_WIDTH{1'b1}};
            end else begin
                dout_d = q_s[DOUT_WIDTH-1:0];
            end
        end else begin
            dout_ch_d  = dout_ch_q;
            dout_sat_d = dout_sat_q;
            dout_d     = dout_q;
        end
    end

    // Sticky saturation flags; a new saturation beats a simultaneous clear.
    always_comb begin
        if (sat_clr) begin
            sat_flags_d = {NUM_CH{1'b0}};
        end else begin
            sat_flags_d = sat_flags_q;
        end
        if (s2_v_q && sat_s) begin
            sat_flags_d[s2_ch_q] = 1'b1;
        end else begin
            sat_flags_d = sat_flags_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                gain_q[i] <= GAIN_RESET;
            end
            s1_v_q      <= 1'b0;
            s1_din_q    <= {DIN_WIDTH{1'b0}};
            s1_ch_q     <= {CH_WIDTH{1'b0}};
            s1_gain_q   <= {GAIN_WIDTH{1'b0}};
            s2_v_q      <= 1'b0;
            s2_prod_q   <= {PW{1'b0}};
            s2_ch_q     <= {CH_WIDTH{1'b0}};
            dout_q      <= {DOUT_WIDTH{1'b0}};
            dout_ch_q   <= {CH_WIDTH{1'b0}};
            dout_v_q    <= 1'b0;
            dout_sat_q  <= 1'b0;
            sat_flags_q <= {NUM_CH{1'b0}};
        end else begin
            gain_q      <= gain_d;
            s1_v_q      <= s1_v_d;
            s1_din_q    <= s1_din_d;
            s1_ch_q     <= s1_ch_d;
            s1_gain_q   <= s1_gain_d;
            s2_v_q      <= s2_v_d;
            s2_prod_q   <= s2_prod_d;
            s2_ch_q     <= s2_ch_d;
            dout_q      <= dout_d;
            dout_ch_q   <= dout_ch_d;
            dout_v_q    <= dout_v_d;
            dout_sat_q  <= dout_sat_d;
            sat_flags_q <= sat_flags_d;
        end
    end

    assign dout      = dout_q;
    assign dout_ch   = dout_ch_q;
    assign dout_v    = dout_v_q;
    assign dout_sat  = dout_sat_q;
    assign sat_flags = sat_flags_q;

endmodule

// File: tb/tb_gain_stage_mc.sv
// Self-checking bench for gain_stage_mc: directed scenarios plus randomized traffic
// compared against an arithmetic reference model with a 3-cycle expectation queue.
module tb_gain_stage_mc;

    localparam int SH   = 12;
    localparam int DMAX = 65535;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gain_we = 1'b0;
    logic [1:0]  gain_addr = 2'd0;
    logic [15:0] gain_wdata = 16'd0;
    logic [15:0] din = 16'd0;
    logic [1:0]  din_ch = 2'd0;
    logic        din_v = 1'b0;
    logic [15:0] dout;
    logic [1:0]  dout_ch;
    logic        dout_v;
    logic        dout_sat;
    logic [3:0]  sat_flags;
    logic        sat_clr = 1'b0;

    gain_stage_mc dut (
        .clk        (clk),
        .rst        (rst),
        .gain_we    (gain_we),
        .gain_addr  (gain_addr),
        .gain_wdata (gain_wdata),
        .din        (din),
        .din_ch     (din_ch),
        .din_v      (din_v),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_v     (dout_v),
        .dout_sat   (dout_sat),
        .sat_flags  (sat_flags),
        .sat_clr    (sat_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        int unsigned dout;
        int unsigned ch;
        bit          sat;
    } exp_t;

    exp_t        pend[$];
    int unsigned mgain[4];
    int unsigned m_flags;
    int unsigned last_dout, last_ch;
    bit          last_sat;
    int          checks = 0;
    int          errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input bit v, input int unsigned d, input int unsigned c);
        exp_t e;
        longint unsigned p, q;
        p = longint'(d) * longint'(mgain[c]);
`ifdef GAIN_STAGE_MC_ROUND_EN
        p = p + (64'd1 << (SH - 1));
`endif
        q = p >> SH;
        e.v   = v;
        e.ch  = c;
        e.sat = (q > DMAX);
        e.dout = e.sat ? DMAX : int'(q);
        return e;
    endfunction

    task automatic model_reset();
        pend.delete();
        for (int i = 0; i < 4; i++) mgain[i] = 32'h1000;
        m_flags   = 0;
        last_dout = 0;
        last_ch   = 0;
        last_sat  = 1'b0;
    endtask

    // One clock: queue expectation for current inputs, advance, then compare outputs.
    task automatic tick();
        exp_t e;
        bit   r, clr;
        r   = rst;
        clr = sat_clr;
        e = model(din_v && !rst, din, din_ch);
        pend.push_back(e);
        if (gain_we && !rst) mgain[gain_addr] = gain_wdata;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
            e.v = 1'b0;
        end else begin
            if (pend.size() >= 3) e = pend.pop_front();
            else e.v = 1'b0;
            if (clr) m_flags = 0;
            if (e.v) begin
                last_dout = e.dout;
                last_ch   = e.ch;
                last_sat  = e.sat;
                if (e.sat) m_flags = m_flags | (32'd1 << e.ch);
            end
        end
        check_val("dout_v",    {31'd0, dout_v},    {31'd0, e.v});
        check_val("dout",      {16'd0, dout},      last_dout);
        check_val("dout_ch",   {30'd0, dout_ch},   last_ch);
        check_val("dout_sat",  {31'd0, dout_sat},  {31'd0, last_sat});
        check_val("sat_flags", {28'd0, sat_flags}, m_flags);
    endtask

    task automatic send(input int unsigned c, input int unsigned d);
        din_v = 1'b1; din = d[15:0]; din_ch = c[1:0];
        tick();
        din_v = 1'b0;
    endtask

    task automatic wgain(input int unsigned c, input int unsigned g);
        gain_we = 1'b1; gain_addr = c[1:0]; gain_wdata = g[15:0];
        tick();
        gain_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(2);

        // Unity gain, back-to-back channels.
        for (int c = 0; c < 4; c++) send(c, 1000);
        idle(4);

        // Per-channel gains.
        wgain(1, 16'h2000);
        wgain(2, 16'h0800);
        send(1, 1000);
        send(2, 1000);
        idle(4);

        // Saturation, sticky flag, clear, clear colliding with a new saturation.
        wgain(3, 16'h2000);
        send(3, 50000);
        send(3, 100);
        idle(4);
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        idle(1);
        send(3, 50000);
        tick();
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        idle(3);

        // Gain write colliding with a sample on the same channel.
        wgain(0, 16'h1000);
        gain_we = 1'b1; gain_addr = 2'd0; gain_wdata = 16'h3000;
        din_v = 1'b1; din = 16'd10; din_ch = 2'd0;
        tick();
        gain_we = 1'b0; din_v = 1'b0;
        send(0, 10);
        idle(4);

        // Rounding behaviour.
        wgain(0, 16'h0800);
        send(0, 3);
        send(0, 2);
        idle(4);

        // Reset mid-stream discards in-flight samples and restores gains.
        send(3, 60000);
        send(1, 500);
        send(2, 700);
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 4; c++) send(c, 7);
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            din_v      = ($urandom_range(0, 3) != 0);
            din        = 16'($urandom);
            din_ch     = 2'($urandom_range(0, 3));
            gain_we    = ($urandom_range(0, 5) == 0);
            gain_addr  = 2'($urandom_range(0, 3));
            gain_wdata = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 16'h2000)) : 16'($urandom);
            sat_clr    = ($urandom_range(0, 11) == 0);
            rst        = ($urandom_range(0, 99) == 0);
            tick();
        end
        din_v = 1'b0; gain_we = 1'b0; sat_clr = 1'b0; rst = 1'b0;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
